// File: rtl/fault_pkg.sv
// Shared types and helpers for the fault mask generator.
//   fault_mode_e  : how the selected bit/bus is corrupted
//   LFSR_POLY     : Galois feedback taps of the 32-bit selection LFSR
//   LFSR_SEED_DEF : reset value and replacement for an all-zero seed
//   lfsr_next()   : one right-shifting Galois step
package fault_pkg;

  typedef enum logic [1:0] {
    FM_FLIP = 2'd0,
    FM_SA0  = 2'd1,
    FM_SA1  = 2'd2,
    FM_WORD = 2'd3
  } fault_mode_e;

  localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED_DEF = 32'h0000_0001;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] r;
    r = {1'b0, s[31:1]};
    if (s[0]) begin
      r = r ^ LFSR_POLY;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/fault_mask_gen_if.sv
// Bus and telemetry bundle of the fault mask generator.
//   sig_in/sig_out : NUM_CH buses of WIDTH bits, channel c at [c*WIDTH +: WIDTH]
//   fault_active   : a fault mask is applied
//   fault_start    : first cycle of a fault
//   fault_ch/bit   : channel and bit of the current or last fault
//   fault_count    : saturating number of faults injected since reset
// master = environment side, slave = injector side.
interface fault_mask_gen_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32,
  parameter int CNT_W  = 16,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH*WIDTH-1:0] sig_in;
  logic [NUM_CH*WIDTH-1:0] sig_out;
  logic                    fault_active;
  logic                    fault_start;
  logic [CH_W-1:0]         fault_ch;
  logic [4:0]              fault_bit;
  logic [CNT_W-1:0]        fault_count;

  modport master (
    output sig_in,
    input  sig_out, fault_active, fault_start, fault_ch, fault_bit, fault_count
  );

  modport slave (
    input  sig_in,
    output sig_out, fault_active, fault_start, fault_ch, fault_bit, fault_count
  );
endinterface

// File: rtl/fi_lfsr.sv
// 32-bit Galois LFSR used to pick fault channel, bit and WORD value.
//   clk, rst_n : clock, async active-low reset (state -> LFSR_SEED_DEF)
//   en         : advance one step this cycle
//   load       : load seed (wins over en); a zero seed becomes LFSR_SEED_DEF
//   seed       : value for load
//   state      : current LFSR register
module fi_lfsr
  import fault_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] seed,
  output logic [31:0] state
);

  logic [31:0] state_d;
  logic [31:0] state_q;

  // Next LFSR value: load beats advance; an all-zero state would lock up
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (seed == 32'h0000_0000) ? LFSR_SEED_DEF : seed;
    end else if (en) begin
      state_d = lfsr_next(state_q);
    end else begin
      state_d = state_q;
    end
  end

  // LFSR register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LFSR_SEED_DEF;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/fault_mask_gen.sv
// Inline transient-fault injector: sig_out = sig_in with a registered mask
// applied to one channel. An IDLE/COUNT/INJECT sequencer waits cfg_interval
// fault-free cycles, then holds a fault for max(cfg_duration,1) cycles.
//   clk, rst_n        : clock, async active-low reset
//   enable            : arm the injector; low returns to IDLE and clears the mask
//   cfg_mode          : fault_mode_e, latched at fault start
//   cfg_interval      : fault-free cycles between faults (0 = never)
//   cfg_duration      : cycles per fault (0 behaves as 1), latched at fault start
//   seed_load/cfg_seed: reload the selection LFSR
//   bus               : slave side of fault_mask_gen_if (buses + telemetry)
module fault_mask_gen
  import fault_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32,
  parameter int POLICY = 0,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_interval,
  input  logic [CNT_W-1:0] cfg_duration,
  input  logic             seed_load,
  input  logic [31:0]      cfg_seed,
  fault_mask_gen_if.slave  bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_COUNT  = 2'd1;
  localparam logic [1:0] ST_INJECT = 2'd2;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CH_W-1:0]  CH_ZERO  = {CH_W{1'b0}};
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

  logic [31:0]      lfsr_s;
  logic [CH_W-1:0]  ch_pick_s;
  logic [4:0]       bit_pick_s;
  logic [1:0]       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [CNT_W-1:0] dcnt_d, dcnt_q;
  logic [CNT_W-1:0] dlast_d, dlast_q;
  logic [CH_W-1:0]  ch_d, ch_q;
  logic [CH_W-1:0]  rr_d, rr_q;
  logic [4:0]       bit_d, bit_q;
  fault_mode_e      mode_d, mode_q;
  logic [WIDTH-1:0] val_d, val_q;
  logic             start_d, start_q;
  logic             active_d, active_q;
  logic [CNT_W-1:0] count_d, count_q;

  fi_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (enable),
    .load  (seed_load),
    .seed  (cfg_seed),
    .state (lfsr_s)
  );

  // Fault target selection from the current LFSR value or the round-robin pointer
  always_comb begin
    if (POLICY == 1) begin
      ch_pick_s = rr_q;
    end else begin
      ch_pick_s = CH_W'(lfsr_s[15:0] % 16'(NUM_CH));
    end
    bit_pick_s = 5'(lfsr_s[31:16] % 16'(WIDTH));
  end

  // Sequencer: interval counting, fault start latching, duration counting
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    dlast_d = dlast_q;
    ch_d    = ch_q;
    rr_d    = rr_q;
    bit_d   = bit_q;
    mode_d  = mode_q;
    val_d   = val_q;
    start_d = 1'b0;
    count_d = count_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_COUNT;
          cnt_d   = CNT_ZERO;
        end
        ST_COUNT: begin
          if ((cfg_interval != CNT_ZERO) && (cnt_q == cfg_interval - CNT_ONE)) begin
            state_d = ST_INJECT;
            dcnt_d  = CNT_ZERO;
            // duration 0 behaves as 1, so the last dcnt value is 0 in both cases
            dlast_d = (cfg_duration == CNT_ZERO) ? CNT_ZERO : cfg_duration - CNT_ONE;
            ch_d    = ch_pick_s;
            rr_d    = (rr_q == CH_LAST) ? CH_ZERO : rr_q + CH_W'(1);
            mode_d  = fault_mode_e'(cfg_mode);
            bit_d   = (cfg_mode == FM_WORD) ? 5'd0 : bit_pick_s;
            val_d   = lfsr_s[WIDTH-1:0];
            start_d = 1'b1;
            count_d = (&count_q) ? count_q : count_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_INJECT: begin
          if (dcnt_q == dlast_q) begin
            state_d = ST_COUNT;
            cnt_d   = CNT_ZERO;
          end else begin
            dcnt_d = dcnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    active_d = (state_d == ST_INJECT);
  end

  // Sequencer and fault descriptor registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      dcnt_q   <= CNT_ZERO;
      dlast_q  <= CNT_ZERO;
      ch_q     <= CH_ZERO;
      rr_q     <= CH_ZERO;
      bit_q    <= 5'd0;
      mode_q   <= FM_FLIP;
      val_q    <= {WIDTH{1'b0}};
      start_q  <= 1'b0;
      active_q <= 1'b0;
      count_q  <= CNT_ZERO;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dcnt_q   <= dcnt_d;
      dlast_q  <= dlast_d;
      ch_q     <= ch_d;
      rr_q     <= rr_d;
      bit_q    <= bit_d;
      mode_q   <= mode_d;
      val_q    <= val_d;
      start_q  <= start_d;
      active_q <= active_d;
      count_q  <= count_d;
    end
  end

  logic [NUM_CH*WIDTH-1:0] sig_out_s;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WIDTH-1:0] in_w;
    logic [WIDTH-1:0] out_w;
    logic [WIDTH-1:0] onehot_w;

    // Per-channel mask: only the latched channel is touched, and only while active
    always_comb begin
      in_w     = bus.sig_in[c*WIDTH +: WIDTH];
      onehot_w = {WIDTH{1'b0}};
      onehot_w[bit_q] = 1'b1;
      out_w    = in_w;
      if (active_q && (ch_q == CH_W'(c))) begin
        case (mode_q)
          FM_FLIP: out_w = in_w ^ onehot_w;
          FM_SA0:  out_w = in_w & ~onehot_w;
          FM_SA1:  out_w = in_w | onehot_w;
          FM_WORD: out_w = val_q;
          default: out_w = in_w;
        endcase
      end else begin
        out_w = in_w;
      end
    end

    assign sig_out_s[c*WIDTH +: WIDTH] = out_w;
  end

  assign bus.sig_out      = sig_out_s;
  assign bus.fault_active = active_q;
  assign bus.fault_start  = start_q;
  assign bus.fault_ch     = ch_q;
  assign bus.fault_bit    = bit_q;
  assign bus.fault_count  = count_q;

endmodule

// File: tb/tb_fault_mask_gen.sv
// Scoreboard bench: a period-arithmetic model predicts every fault; two
// injectors (random and round-robin channel policy) share one stimulus.
module tb_fault_mask_gen;
  localparam int NUM_CH = 4;
  localparam int WIDTH  = 32;
  localparam int CNT_W  = 16;
  localparam int BW     = NUM_CH * WIDTH;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             seed_load = 1'b0;
  logic [1:0]       cfg_mode = 2'd0;
  logic [CNT_W-1:0] cfg_interval = 16'd0;
  logic [CNT_W-1:0] cfg_duration = 16'd0;
  logic [31:0]      cfg_seed = 32'd0;
  logic [BW-1:0]    sig_in = '0;
  int               sig_mode = 0;   // 0 random, 1 all zeros, 2 all ones

  fault_mask_gen_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .CNT_W(CNT_W)) bus0 ();
  fault_mask_gen_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .CNT_W(CNT_W)) bus1 ();
  assign bus0.sig_in = sig_in;
  assign bus1.sig_in = sig_in;

  fault_mask_gen #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .POLICY(0), .CNT_W(CNT_W)) u_rand (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_mode(cfg_mode),
    .cfg_interval(cfg_interval), .cfg_duration(cfg_duration),
    .seed_load(seed_load), .cfg_seed(cfg_seed), .bus(bus0.slave));

  fault_mask_gen #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .POLICY(1), .CNT_W(CNT_W)) u_rr (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_mode(cfg_mode),
    .cfg_interval(cfg_interval), .cfg_duration(cfg_duration),
    .seed_load(seed_load), .cfg_seed(cfg_seed), .bus(bus1.slave));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] m_lfsr;
  bit          m_run, m_active, m_start;
  int          m_t, m_bit, m_count, m_rr;
  int          m_ch [2];
  logic [1:0]  m_mode;
  logic [31:0] m_val;

  typedef struct { int ch; int bt; int cnt; } ev_t;
  ev_t q0[$];
  ev_t q1[$];

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] galois(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  task automatic model_reset();
    m_lfsr = 32'h1; m_run = 0; m_active = 0; m_start = 0; m_t = 0;
    m_bit = 0; m_count = 0; m_rr = 0; m_ch[0] = 0; m_ch[1] = 0;
    m_mode = 2'd0; m_val = 32'h0;
    q0.delete(); q1.delete();
  endtask

  // One clock edge of the model: faults start at t = I + k*(I+D), t counted
  // from the edge on which enable was first sampled high.
  task automatic model_update();
    logic [31:0] old;
    int i_v, d_v, ph;
    old = m_lfsr;
    m_start = 0;
    if (!enable) begin
      m_run = 0; m_active = 0;
    end else begin
      if (!m_run) begin m_run = 1; m_t = 0; end
      else m_t++;
      i_v = int'(cfg_interval);
      d_v = (cfg_duration == 16'd0) ? 1 : int'(cfg_duration);
      ph  = m_t - i_v;
      m_active = (i_v != 0) && (ph >= 0) && ((ph % (i_v + d_v)) < d_v);
      m_start  = (i_v != 0) && (ph >= 0) && ((ph % (i_v + d_v)) == 0);
      if (m_start) begin
        m_ch[0] = int'(old[15:0]) % NUM_CH;
        m_ch[1] = m_rr;
        m_rr    = (m_rr + 1) % NUM_CH;
        m_mode  = cfg_mode;
        m_bit   = (cfg_mode == 2'd3) ? 0 : int'(old[31:16]) % WIDTH;
        m_val   = old;
        if (m_count < 65535) m_count++;
        q0.push_back('{m_ch[0], m_bit, m_count});
        q1.push_back('{m_ch[1], m_bit, m_count});
      end
    end
    if (seed_load) m_lfsr = (cfg_seed == 32'h0) ? 32'h1 : cfg_seed;
    else if (enable) m_lfsr = galois(m_lfsr);
  endtask

  function automatic logic [BW-1:0] exp_out(input logic [BW-1:0] si, input bit act,
                                            input int ch, input int bt,
                                            input logic [1:0] md, input logic [31:0] v);
    logic [BW-1:0] r;
    int base;
    r = si;
    base = ch * WIDTH;
    if (act) begin
      case (md)
        2'd0: r[base+bt] = ~si[base+bt];
        2'd1: r[base+bt] = 1'b0;
        2'd2: r[base+bt] = 1'b1;
        default: for (int i = 0; i < WIDTH; i++) r[base+i] = v[i];
      endcase
    end
    return r;
  endfunction

  task automatic check_dut(input int k, input logic [BW-1:0] so, input logic act,
                           input logic st, input logic [1:0] ch, input logic [4:0] bt,
                           input logic [CNT_W-1:0] cnt);
    ev_t e;
    chk($sformatf("active[%0d]", k), BW'(act), BW'(m_active));
    chk($sformatf("start[%0d]", k), BW'(st), BW'(m_start));
    chk($sformatf("ch[%0d]", k), BW'(ch), BW'(m_ch[k]));
    chk($sformatf("bit[%0d]", k), BW'(bt), BW'(m_bit));
    chk($sformatf("count[%0d]", k), BW'(cnt), BW'(m_count));
    chk($sformatf("sig_out[%0d]", k), so, exp_out(sig_in, m_active, m_ch[k], m_bit, m_mode, m_val));
    if (m_active && m_mode == 2'd0)
      chk($sformatf("flip_onebit[%0d]", k), BW'($countones(so ^ sig_in)), BW'(1));
    if (st) begin
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        chk($sformatf("sb_unexpected_start[%0d]", k), BW'(1), BW'(0));
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("sb_ch[%0d]", k), BW'(ch), BW'(e.ch));
        chk($sformatf("sb_bit[%0d]", k), BW'(bt), BW'(e.bt));
        chk($sformatf("sb_cnt[%0d]", k), BW'(cnt), BW'(e.cnt));
      end
    end
  endtask

  // Monitor: compares both injectors on the falling edge
  always @(negedge clk) begin
    check_dut(0, bus0.sig_out, bus0.fault_active, bus0.fault_start,
              bus0.fault_ch, bus0.fault_bit, bus0.fault_count);
    check_dut(1, bus1.sig_out, bus1.fault_active, bus1.fault_start,
              bus1.fault_ch, bus1.fault_bit, bus1.fault_count);
  end

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_update();
    #2;
    case (sig_mode)
      0: sig_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      1: sig_in = '0;
      default: sig_in = '1;
    endcase
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    run(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_active();
    for (int i = 0; i < 60 && !bus0.fault_active; i++) tick();
    chk("wait_inject", BW'(bus0.fault_active), BW'(1));
  endtask

  task automatic load_seed(input logic [31:0] s);
    cfg_seed = s; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  initial begin
    model_reset();
    sig_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    // 1: reset, idle for 50 cycles
    run(3);
    rst_n = 1'b1;
    run(50);
    // 2: interval 4, duration 2, FLIP
    cfg_interval = 16'd4; cfg_duration = 16'd2; cfg_mode = 2'd0;
    enable = 1'b1;
    run(20);
    enable = 1'b0;
    tick();
    // 3: round-robin sequence 0,1,2,3,0 with interval 1, duration 1
    do_reset();
    cfg_interval = 16'd1; cfg_duration = 16'd1;
    enable = 1'b1;
    run(10);
    enable = 1'b0;
    tick();
    chk("rr_count", BW'(bus1.fault_count), BW'(5));
    // 4: SA1 on zeros, SA0 on ones (duration 0 behaves as 1)
    cfg_interval = 16'd3; cfg_duration = 16'd2; cfg_mode = 2'd2; sig_mode = 1;
    enable = 1'b1;
    run(20);
    enable = 1'b0;
    tick();
    cfg_duration = 16'd0; cfg_mode = 2'd1; sig_mode = 2;
    enable = 1'b1;
    run(20);
    enable = 1'b0;
    tick();
    sig_mode = 0;
    // 5: WORD mode after seed 0 and after seed 1
    cfg_interval = 16'd2; cfg_duration = 16'd3; cfg_mode = 2'd3;
    load_seed(32'h0);
    enable = 1'b1;
    run(25);
    enable = 1'b0;
    tick();
    load_seed(32'h1);
    enable = 1'b1;
    run(25);
    enable = 1'b0;
    tick();
    // 6: drop enable three cycles into an 8-cycle fault, then restart
    cfg_interval = 16'd3; cfg_duration = 16'd8; cfg_mode = 2'd0;
    load_seed($urandom() | 32'h1);
    enable = 1'b1;
    wait_active();
    run(2);
    enable = 1'b0;
    tick();
    chk("drop_active", BW'(bus0.fault_active), BW'(0));
    run(3);
    enable = 1'b1;
    run(30);
    // 6a: async reset in the middle of a fault
    wait_active();
    run(2);
    rst_n = 1'b0;
    enable = 1'b0;
    model_reset();
    #1;
    chk("rst_sig_out0", bus0.sig_out, sig_in);
    chk("rst_sig_out1", bus1.sig_out, sig_in);
    chk("rst_active", BW'(bus0.fault_active), BW'(0));
    run(2);
    rst_n = 1'b1;
    run(2);
    // 7: interval 0 never injects
    cfg_interval = 16'd0; cfg_duration = 16'd5;
    enable = 1'b1;
    run(1000);
    enable = 1'b0;
    tick();
    chk("never_count", BW'(bus0.fault_count), BW'(0));
    chk("sb_drained0", BW'(q0.size()), BW'(0));
    chk("sb_drained1", BW'(q1.size()), BW'(0));
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
